// File: rtl/hw_custom_top.sv
// DSP link-test block: command decoder, PRBS/equalizer test datapath and 32768x32 logging RAM.
// Optional PRBS bit/error checker and its ops 5/6 are built only when HW_CUSTOM_PRBS_EN is defined.
`timescale 1ns/1ps
module hw_custom_top (
  input  logic        clockdsp,
  input  logic        i_reset,
  input  logic [31:0] gpio_output_to_input_dsp,
  output logic [31:0] gpio_input_to_output_dsp
);

  typedef struct packed {
    logic [7:0]  op;
    logic        valid;
    logic        rd;
    logic [14:0] addr;
  } cmd_t;

  typedef enum logic [1:0] {SEL_HOLD, SEL_RAM, SEL_AUX} sel_t;

  localparam logic [8:0]  PRBS_SEED = 9'h1FF;
  localparam logic [27:0] COEF_INIT = 28'h2000000;
  localparam logic [7:0]  COEF_SKIP = 8'd250;

  cmd_t        cmd_q;
  logic        soft_rst_q, adapt_q, armed, full;
  logic [3:0]  log_sub_q;
  logic [14:0] waddr;
  logic [7:0]  br_cnt;
  logic [1:0]  phase_q;
  logic [8:0]  prbs_q;
  logic [11:0] dec_q;
  logic [27:0] coef_q;
  logic        log_we;
  logic [31:0] log_data;

  // NOTE: every sequential block uses non-blocking (<=) so all registers sample pre-edge values.
  always_ff @(posedge clockdsp) begin
    if (i_reset) cmd_q <= '0;
    else cmd_q <= '{op: gpio_output_to_input_dsp[31:24], valid: gpio_output_to_input_dsp[23],
                    rd: gpio_output_to_input_dsp[16], addr: gpio_output_to_input_dsp[14:0]};
  end

  logic [3:0] sub;
  logic       bit0;
  assign sub  = cmd_q.addr[3:0];
  assign bit0 = cmd_q.addr[0];

  function automatic logic is_op(input cmd_t c, input logic [7:0] code);
    return c.valid && (c.op == code);
  endfunction

  function automatic logic sub_ok(input logic [3:0] s);
    return s inside {4'h9, 4'hA, 4'hB, 4'hC};
  endfunction

  // Datapath strobes are suppressed during soft reset so no log write or count slips in.
  logic        br, br2, b;
  logic [7:0]  fse_d;
  logic [11:0] slc_d, dec_d, err_d;
  logic [27:0] coef_nx;
  assign br      = !soft_rst_q && (phase_q == 2'd3);
  assign br2     = !soft_rst_q && phase_q[0];
  assign b       = prbs_q[8];
  assign fse_d   = b ? 8'hC0 : 8'h40;
  assign slc_d   = {{2{fse_d[7]}}, fse_d, 2'b00};
  assign dec_d   = slc_d[11] ? 12'hF00 : 12'h100;
  assign err_d   = slc_d - dec_q;
  assign coef_nx = adapt_q ? coef_q + 28'd1 : coef_q;

  always_ff @(posedge clockdsp) begin
    if (i_reset || soft_rst_q) begin
      phase_q <= '0;
      prbs_q  <= PRBS_SEED;
      dec_q   <= '0;
      coef_q  <= COEF_INIT;
    end else begin
      phase_q <= phase_q + 2'd1;
      if (br) begin
        prbs_q <= {prbs_q[7:0], prbs_q[8] ^ prbs_q[4]};
        dec_q  <= dec_d;
        coef_q <= coef_nx;
      end
    end
  end

  always_ff @(posedge clockdsp) begin
    if (i_reset) begin
      soft_rst_q <= 1'b0;
      adapt_q    <= 1'b0;
      log_sub_q  <= '0;
      armed      <= 1'b0;
      full       <= 1'b0;
      waddr      <= '0;
      br_cnt     <= '0;
    end else begin
      if (is_op(cmd_q, 8'd1)) soft_rst_q <= bit0;
      if (is_op(cmd_q, 8'd2)) adapt_q <= bit0;
      if (br && br_cnt != COEF_SKIP) br_cnt <= br_cnt + 8'd1;
      if (log_we) begin
        if (waddr == 15'h7FFF) begin
          full  <= 1'b1;
          armed <= 1'b0;
        end else begin
          waddr <= waddr + 15'd1;
        end
      end
      // Arming is edge-like: only a change to a new valid source restarts the log.
      if (is_op(cmd_q, 8'd3)) begin
        log_sub_q <= sub;
        if (!sub_ok(sub)) begin
          armed <= 1'b0;
        end else if (sub != log_sub_q) begin
          armed  <= 1'b1;
          full   <= 1'b0;
          waddr  <= '0;
          br_cnt <= '0;
        end
      end
    end
  end

  // NOTE: always_comb outputs get defaults first so no path leaves them unassigned (no latch).
  always_comb begin
    log_we   = 1'b0;
    log_data = '0;
    if (armed) begin
      case (log_sub_q)
        4'h9: begin
          // Even addresses start on phase 1 so each symbol's two samples share a pair.
          log_we   = br2 && (waddr[0] == phase_q[1]);
          log_data = {{24{fse_d[7]}}, fse_d};
        end
        4'hA: begin
          log_we   = br;
          log_data = {{20{slc_d[11]}}, slc_d};
        end
        4'hB: begin
          log_we   = br && (br_cnt == COEF_SKIP);
          log_data = {{4{coef_nx[27]}}, coef_nx};
        end
        4'hC: begin
          log_we   = br;
          log_data = {{20{err_d[11]}}, err_d};
        end
        default: ;
      endcase
    end
  end

  logic [31:0] mem [0:32767];
  logic [31:0] ram_q;
  // NOTE: the RAM array is deliberately not reset; a read of the written address returns old data.
  always_ff @(posedge clockdsp) begin
    if (log_we) mem[waddr] <= log_data;
    ram_q <= mem[cmd_q.addr];
  end

`ifdef HW_CUSTOM_PRBS_EN
  logic [8:0]  chk_q;
  logic [31:0] bit_cnt, err_cnt;
  logic        cap_q;
  always_ff @(posedge clockdsp) begin
    if (i_reset) cap_q <= 1'b0;
    else if (is_op(cmd_q, 8'd5)) cap_q <= bit0;
  end
  always_ff @(posedge clockdsp) begin
    if (i_reset || soft_rst_q) begin
      chk_q   <= PRBS_SEED;
      bit_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (br) chk_q <= {chk_q[7:0], chk_q[8] ^ chk_q[4]};
      if (is_op(cmd_q, 8'd5) && bit0 && !cap_q) begin
        bit_cnt <= '0;
        err_cnt <= '0;
      end else if (cap_q && br) begin
        if (bit_cnt != '1) bit_cnt <= bit_cnt + 32'd1;
        if ((dec_d[11] != chk_q[8]) && (err_cnt != '1)) err_cnt <= err_cnt + 32'd1;
      end
    end
  end
`endif

  sel_t        sel_q;
  logic [31:0] aux_q;
  always_ff @(posedge clockdsp) begin
    if (i_reset) begin
      sel_q <= SEL_HOLD;
      aux_q <= '0;
      gpio_input_to_output_dsp <= '0;
    end else begin
      aux_q <= {30'b0, armed, full};
      if (!cmd_q.valid) sel_q <= SEL_HOLD;
      else if (cmd_q.op == 8'd4 && cmd_q.rd) sel_q <= SEL_RAM;
      else sel_q <= SEL_AUX;
`ifdef HW_CUSTOM_PRBS_EN
      if (is_op(cmd_q, 8'd6)) aux_q <= bit0 ? err_cnt : bit_cnt;
`endif
      case (sel_q)
        SEL_RAM: gpio_input_to_output_dsp <= ram_q;
        SEL_AUX: gpio_input_to_output_dsp <= aux_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hw_custom_top.sv
// Scoreboard bench for hw_custom_top: reads are queued with their expected word and checked 3 clocks later.
// Soft reset is held while arming so every log starts from the PRBS9 seed.
`timescale 1ns/1ps
module tb_hw_custom_top;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cmd, resp;

  always #5 clk = ~clk;

  hw_custom_top dut (
    .clockdsp                (clk),
    .i_reset                 (rst),
    .gpio_output_to_input_dsp(cmd),
    .gpio_input_to_output_dsp(resp)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  string       tag_q [$];
  logic [31:0] exp_q [$];
  int          due_q [$];
  logic        pb [16384];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    while (due_q.size() > 0 && due_q[0] <= cyc) begin
      check(tag_q.pop_front(), resp, exp_q.pop_front());
      void'(due_q.pop_front());
    end
  end

  task automatic send(input logic [31:0] w, input int n);
    @(negedge clk);
    cmd = w;
    repeat (n) @(posedge clk);
  endtask

  task automatic expect_rd(input logic [31:0] w, input logic [31:0] exp, input string tag);
    @(negedge clk);
    cmd = w;
    tag_q.push_back(tag);
    exp_q.push_back(exp);
    due_q.push_back(cyc + 3);
  endtask

  task automatic drain();
    int guard = 0;
    while (due_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (due_q.size() > 0) begin
      check("drain_timeout", due_q.size(), 0);
      tag_q.delete();
      exp_q.delete();
      due_q.delete();
    end
  endtask

  function automatic logic [31:0] fse_w(input int i);
    return pb[i / 2] ? 32'hFFFFFFC0 : 32'h00000040;
  endfunction

  function automatic logic [31:0] slc_w(input int k);
    return pb[k] ? 32'hFFFFFF00 : 32'h00000100;
  endfunction

  function automatic logic [31:0] err_w(input int k);
    logic [11:0] s, p, e;
    s = pb[k] ? 12'hF00 : 12'h100;
    p = (k == 0) ? 12'h000 : (pb[k - 1] ? 12'hF00 : 12'h100);
    e = s - p;
    return {{20{e[11]}}, e};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] s;
    logic [31:0] bit_exp;
    s = 9'h1FF;
    for (int k = 0; k < 16384; k++) begin
      pb[k] = s[8];
      s = {s[7:0], s[8] ^ s[4]};
    end
`ifdef HW_CUSTOM_PRBS_EN
    bit_exp = 32'd1000;
`else
    bit_exp = 32'd0;
`endif

    rst = 1'b1;
    cmd = '0;
    repeat (3) @(posedge clk);
    #1 check("reset_resp", resp, 32'h0);
    @(negedge clk) rst = 1'b0;

    expect_rd(32'h04800000, 32'h0, "reset_status");
    drain();

    // PRBS counters: capture armed under soft reset, run exactly 4000 clocks.
    send(32'h01800001, 4);
    send(32'h05800001, 4);
    send(32'h01800000, 4000);
    send(32'h05800000, 4);
    expect_rd(32'h06800000, bit_exp, "bit_count");
    expect_rd(32'h06000001, bit_exp, "invalid_hold");
    expect_rd(32'h06800001, 32'h0, "err_count");
    drain();

    // FSE log until full.
    send(32'h01800001, 4);
    send(32'h03800009, 4);
    send(32'h01800000, 70000);
    expect_rd(32'h04800000, 32'h1, "fse_full_status");
    for (int i = 0; i < 64; i++) expect_rd(32'h04810000 | i, fse_w(i), "fse_word");
    expect_rd(32'h04817FFE, fse_w(32766), "fse_word_32766");
    expect_rd(32'h04817FFF, fse_w(32767), "fse_word_32767");
    drain();

    // Slicer log: arming clears full.
    send(32'h01800001, 4);
    send(32'h0380000A, 4);
    expect_rd(32'h04800000, 32'h2, "slc_armed_status");
    drain();
    send(32'h01800000, 1000);
    send(32'h03800000, 4);
    expect_rd(32'h04800000, 32'h0, "slc_stop_status");
    for (int i = 0; i < 200; i++) expect_rd(32'h04810000 | i, slc_w(i), "slc_word");
    drain();

    // Coefficient log: first word lands on the 251st BR after release.
    send(32'h01800001, 4);
    send(32'h02800001, 4);
    send(32'h0380000B, 4);
    send(32'h01800000, 1900);
    send(32'h03800000, 4);
    send(32'h02800000, 4);
    for (int i = 0; i < 100; i++)
      expect_rd(32'h04810000 | i, 32'h02000000 + 32'd251 + i, "coef_word");
    drain();

    // Short FSE log stopped after 100 clocks; coefficient words above it must survive.
    send(32'h01800001, 4);
    send(32'h03800009, 4);
    send(32'h01800000, 100);
    send(32'h03800000, 20);
    expect_rd(32'h04800000, 32'h0, "stop_status");
    for (int i = 0; i < 40; i++) expect_rd(32'h04810000 | i, fse_w(i), "stop_fse_word");
    for (int i = 80; i < 90; i++)
      expect_rd(32'h04810000 | i, 32'h02000000 + 32'd251 + i, "frozen_word");
    drain();

    // Re-arm with the error source: restarts at address 0.
    send(32'h01800001, 4);
    send(32'h0380000C, 4);
    send(32'h01800000, 600);
    send(32'h03800000, 4);
    for (int i = 0; i < 100; i++) expect_rd(32'h04810000 | i, err_w(i), "err_word");
    drain();

    // Reset in the middle of an armed log.
    send(32'h03800009, 4);
    expect_rd(32'h04800000, 32'h2, "pre_reset_status");
    drain();
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("mid_reset_resp", resp, 32'h0);
    @(negedge clk) rst = 1'b0;
    expect_rd(32'h04800000, 32'h0, "post_reset_status");
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
